// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter with a per-frame latched bit period.
// Idle-high registered serial output; back-to-back frames chain from STOP directly to START.
module uart_tx_fifo #(
   parameter int DIV_W = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     resetb,
   input  logic [DIV_W-1:0]         clk_div,
   input  logic                     tx_en,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [7:0]       mem_q [DEPTH];

   logic             push, pop, can_pop, bit_end;
   logic [DIV_W-1:0] div_eff;

   assign in_ready   = (level_q != LW'(DEPTH));
   assign push       = in_valid && in_ready;
   assign can_pop    = tx_en && (level_q != '0);
   assign div_eff    = (clk_div == '0) ? DIV_W'(1) : clk_div;
   assign bit_end    = (cnt_q == div_q - DIV_W'(1));

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE);
   assign fifo_level = level_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               div_d   = div_eff;
               cnt_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // shift_q[1] is the next data bit before this shift lands
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (can_pop) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  div_d   = div_eff;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q  <= IDLE;
         div_q    <= DIV_W'(1);
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      level_q <= level_q + LW'(1);
         else if (pop && !push) level_q <= level_q - LW'(1);
      end
   end

   // Storage needs no reset: level and pointers define which entries are live.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

endmodule
